hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 129 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Register hazard scoreboard for an in-order issue stage. Each architectural
//   register has a small countdown that holds the number of cycles until its
//   pending write-back lands. The issue stage is stalled for RAW hazards the
//   bypass network cannot cover, and for WAW hazards that would let a younger
//   write complete before an older one.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   issue_valid   instruction present in the issue register
//   src0/src1     source register indices, qualified by src0_used/src1_used
//   dst           destination register index, qualified by dst_valid
//   issue_lat     cycles until dst is written back (clamped to MAX_LAT)
//   squash_valid  cancel the pending write to squash_dst
//   stall         issue must hold this cycle
//   busy          bit r set while register r has a pending write
//   stall_cycles  saturating count of stalled cycles

module hazard_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_LAT   = 4,
  parameter int LAT_W     = 3,
  parameter int FWD_LEVEL = 1,
  parameter int R0_ZERO   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   src0,
  input  logic [ADDR_W-1:0]   src1,
  input  logic                src0_used,
  input  logic                src1_used,
  input  logic [ADDR_W-1:0]   dst,
  input  logic                dst_valid,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic                squash_valid,
  input  logic [ADDR_W-1:0]   squash_dst,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy,
  output logic [31:0]         stall_cycles
);

  // Lowest register index that is tracked; r0 is skipped when hardwired.
  localparam int FIRST = (R0_ZERO != 0) ? 1 : 0;

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  logic [LAT_W-1:0] cnt_src0, cnt_src1, cnt_dst;
  logic [LAT_W-1:0] eff_lat;
  logic             dst_write;
  logic             raw0, raw1, waw;
  logic             accept;

  // Look up the countdowns of the addressed registers. Indices that are not
  // tracked (r0 when hardwired, or beyond NUM_REGS) read as zero, so they can
  // never cause a stall.
  always_comb begin
    cnt_src0 = '0;
    cnt_src1 = '0;
    cnt_dst  = '0;
    for (int r = FIRST; r < NUM_REGS; r++) begin
      if (src0 == ADDR_W'(r)) cnt_src0 = cnt_q[r];
      if (src1 == ADDR_W'(r)) cnt_src1 = cnt_q[r];
      if (dst  == ADDR_W'(r)) cnt_dst  = cnt_q[r];
    end
  end

  // Hazard detection. A zero latency write is treated as no write at all,
  // so it neither creates a WAW hazard nor updates the scoreboard.
  always_comb begin
    eff_lat   = (int'(issue_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : issue_lat;
    dst_write = dst_valid && (eff_lat != '0);
    raw0      = src0_used && (int'(cnt_src0) > FWD_LEVEL);
    raw1      = src1_used && (int'(cnt_src1) > FWD_LEVEL);
    waw       = dst_write && (cnt_dst > eff_lat);
    stall     = issue_valid && (raw0 || raw1 || waw);
    accept    = issue_valid && !stall;
  end

  // Next countdown values: decrement, then squash, then an accepted issue,
  // so an issue to the same register as a squash wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_W'(1)) : '0;
      if (squash_valid && (squash_dst == ADDR_W'(r))) begin
        cnt_d[r] = '0;
      end
      if (r >= FIRST && accept && dst_write && (dst == ADDR_W'(r))) begin
        cnt_d[r] = eff_lat;
      end
    end
  end

  // Saturating stall counter.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed test of hazard_scoreboard with default parameters
//   (32 registers, MAX_LAT 4, FWD_LEVEL 1, r0 hardwired).
//   Inputs change on the falling edge; combinational stall is sampled 1ns
//   later and registered state is sampled on the following falling edge.

module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  src0, src1, dst, squash_dst;
  logic        src0_used, src1_used, dst_valid, squash_valid;
  logic [2:0]  issue_lat;
  logic        stall;
  logic [31:0] busy;
  logic [31:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .src0         (src0),
    .src1         (src1),
    .src0_used    (src0_used),
    .src1_used    (src1_used),
    .dst          (dst),
    .dst_valid    (dst_valid),
    .issue_lat    (issue_lat),
    .squash_valid (squash_valid),
    .squash_dst   (squash_dst),
    .stall        (stall),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one issue-slot worth of inputs.
  task automatic applyStimulus(input logic iv,
                               input logic [4:0] s0, input logic s0u,
                               input logic [4:0] s1, input logic s1u,
                               input logic [4:0] d, input logic dv, input logic [2:0] lat,
                               input logic sqv, input logic [4:0] sqd);
    issue_valid  = iv;
    src0         = s0;
    src0_used    = s0u;
    src1         = s1;
    src1_used    = s1u;
    dst          = d;
    dst_valid    = dv;
    issue_lat    = lat;
    squash_valid = sqv;
    squash_dst   = sqd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0);
  endtask

  // Writer: issue with destination and latency only.
  task automatic issueWrite(input logic [4:0] d, input logic [2:0] lat);
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, d, 1'b1, lat, 1'b0, 5'd0);
  endtask

  // Reader: issue that reads src0 and writes nothing.
  task automatic issueRead0(input logic [4:0] s);
    applyStimulus(1'b1, s, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0);
  endtask

  // Advance one clock, landing on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_stall", 64'(stall), 64'd0);
    checkOutput("reset_stall_cycles", 64'(stall_cycles), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // RAW: writer r5 lat 3; reader arrives when cnt[5]=2, stalls once,
    // goes through at cnt[5]=1 via the bypass.
    issueWrite(5'd5, 3'd3);
    #1 checkOutput("raw_writer_stall", 64'(stall), 64'd0);
    step();
    checkOutput("raw_busy5", 64'(busy), 64'h20);
    idle();
    step();
    issueRead0(5'd5);
    #1 checkOutput("raw_stall_cnt2", 64'(stall), 64'd1);
    step();
    checkOutput("raw_nostall_cnt1", 64'(stall), 64'd0);
    step();
    idle();
    checkOutput("raw_stall_cycles", 64'(stall_cycles), 64'd1);

    // r0 is hardwired: writing it tracks nothing, reading it never stalls.
    issueWrite(5'd0, 3'd4);
    step();
    checkOutput("r0_busy", 64'(busy), 64'd0);
    issueRead0(5'd0);
    #1 checkOutput("r0_read_stall", 64'(stall), 64'd0);
    step();
    idle();

    // WAW: r7 lat 4, younger r7 lat 1 presented at cnt[7]=3 -> stalls at 3 and 2.
    issueWrite(5'd7, 3'd4);
    step();
    idle();
    step();
    issueWrite(5'd7, 3'd1);
    #1 checkOutput("waw_stall_cnt3", 64'(stall), 64'd1);
    step();
    checkOutput("waw_stall_cnt2", 64'(stall), 64'd1);
    step();
    checkOutput("waw_nostall_cnt1", 64'(stall), 64'd0);
    step();
    idle();
    checkOutput("waw_busy7_after", 64'(busy), 64'h80);
    step();
    checkOutput("waw_busy7_clear", 64'(busy), 64'd0);
    checkOutput("waw_stall_cycles", 64'(stall_cycles), 64'd3);

    // A hazard with issue_valid low never stalls.
    issueWrite(5'd8, 3'd4);
    step();
    applyStimulus(1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 3'd1, 1'b0, 5'd0);
    #1 checkOutput("novalid_stall", 64'(stall), 64'd0);
    idle();
    for (int i = 0; i < 4; i++) step();
    checkOutput("drain_busy", 64'(busy), 64'd0);

    // Squash cancels a pending write; the reader then goes straight through.
    issueWrite(5'd9, 3'd4);
    step();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b1, 5'd9);
    step();
    checkOutput("squash_busy9", 64'(busy), 64'd0);
    issueRead0(5'd9);
    #1 checkOutput("squash_reader_stall", 64'(stall), 64'd0);
    step();
    idle();

    // Same-cycle issue and squash of r3: the issue wins.
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd2, 1'b1, 5'd3);
    #1 checkOutput("issue_squash_stall", 64'(stall), 64'd0);
    step();
    idle();
    checkOutput("issue_squash_busy_cnt2", 64'(busy), 64'h8);
    step();
    checkOutput("issue_squash_busy_cnt1", 64'(busy), 64'h8);
    step();
    checkOutput("issue_squash_busy_cnt0", 64'(busy), 64'd0);

    // Latency 7 is clamped to 4: a following lat-4 write to r4 has no WAW,
    // and r4 stays busy for exactly four cycles.
    issueWrite(5'd4, 3'd7);
    step();
    issueWrite(5'd4, 3'd4);
    #1 checkOutput("clamp_waw_stall", 64'(stall), 64'd0);
    idle();
    for (int i = 0; i < 3; i++) step();
    checkOutput("clamp_busy_cnt1", 64'(busy), 64'h10);
    step();
    checkOutput("clamp_busy_cnt0", 64'(busy), 64'd0);

    // Latency 0 is no write.
    issueWrite(5'd6, 3'd0);
    step();
    idle();
    checkOutput("lat0_busy", 64'(busy), 64'd0);

    // Reset clears the stall counter, then gather ten stall cycles.
    rst = 1'b0;
    #1 checkOutput("rst_clear_cycles", 64'(stall_cycles), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      issueWrite(5'd10, 3'd4);
      step();
      applyStimulus(1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 3'd0, 1'b0, 5'd0);
      for (int i = 0; i < 4; i++) step();
      idle();
    end
    issueWrite(5'd11, 3'd2);
    step();
    issueRead0(5'd11);
    step();
    step();
    idle();
    checkOutput("ten_stall_cycles", 64'(stall_cycles), 64'd10);

    // Reset mid-operation with a pending write and a stalled reader.
    issueWrite(5'd12, 3'd4);
    step();
    checkOutput("pre_rst_busy12", 64'(busy), 64'h1000);
    issueRead0(5'd12);
    #1 checkOutput("pre_rst_stall", 64'(stall), 64'd1);
    checkOutput("pre_rst_cycles", 64'(stall_cycles), 64'd10);
    rst = 1'b0;
    #1;
    checkOutput("rst_cycles_zero", 64'(stall_cycles), 64'd0);
    checkOutput("rst_busy_zero", 64'(busy), 64'd0);
    checkOutput("rst_stall_zero", 64'(stall), 64'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issueRead0(5'd12);
    #1 checkOutput("post_rst_reader_stall", 64'(stall), 64'd0);
    step();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
